rom_sequence_player: RTL and testbench

//  Plays the first N entries of the 8x8 one-hot pattern ROM in order on the LED bank.

---
 rtl/rom_sequence_player_if.sv | 34 +++
 rtl/rom_sequence_player.sv | 165 ++++++++++++++++
 tb/tb_rom_sequence_player.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/rom_sequence_player_if.sv
`default_nettype none
// ============================================================================
//  Module      : rom_sequence_player_if
//  Description : Bundle of the player's control, ROM and LED signals.
//                Suffixes are named from the player's point of view.
//  Revision    : 1.0  initial release
// ============================================================================
interface rom_sequence_player_if #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 8
) ();
   logic              start_i;
   logic [3:0]        length_i;
   logic              abort_i;
   logic [DATA_W-1:0] rom_data_i;
   logic [ADDR_W-1:0] rom_address_o;
   logic [DATA_W-1:0] leds_o;
   logic [ADDR_W-1:0] step_o;
   logic              busy_o;
   logic              done_o;

   // Game FSM / ROM side
   modport master (
      output start_i, length_i, abort_i, rom_data_i,
      input  rom_address_o, leds_o, step_o, busy_o, done_o
   );

   // Player side
   modport slave (
      input  start_i, length_i, abort_i, rom_data_i,
      output rom_address_o, leds_o, step_o, busy_o, done_o
   );
endinterface
`default_nettype wire

// File: rtl/rom_sequence_player.sv
`default_nettype none
// ============================================================================
//  Module      : rom_sequence_player
//  Description : Plays the first N patterns of a synchronous-read ROM on the
//                LED bank, each shown ON_CYCLES clocks then blanked
//                OFF_CYCLES clocks. Start/length/abort come from the game FSM.
//  Revision    : 1.0  initial release
// ============================================================================
module rom_sequence_player #(
   parameter int ON_CYCLES  = 4,
   parameter int OFF_CYCLES = 2,
   parameter int ADDR_W     = 3,
   parameter int DATA_W     = 8
) (
   input  logic clock_i,
   input  logic reset_n_i,
   rom_sequence_player_if.slave bus
);

   localparam int DEPTH   = 2 ** ADDR_W;
   localparam int LEN_W   = ADDR_W + 1;
   localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int TMR_W   = $clog2(MAX_CYC) + 1;

   localparam logic [LEN_W-1:0]  C_DEPTH    = LEN_W'(DEPTH);
   localparam logic [LEN_W-1:0]  C_LEN_ONE  = LEN_W'(1);
   localparam logic [LEN_W-1:0]  C_LEN_ZERO = '0;
   localparam logic [ADDR_W-1:0] C_STEP_ONE = ADDR_W'(1);
   localparam logic [TMR_W-1:0]  C_TMR_ONE  = TMR_W'(1);
   localparam logic [TMR_W-1:0]  C_ON_LAST  = TMR_W'(ON_CYCLES - 1);
   localparam logic [TMR_W-1:0]  C_OFF_LAST = TMR_W'(OFF_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_LATCH = 3'd2,
      S_SHOW  = 3'd3,
      S_GAP   = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [LEN_W-1:0]    len_q,   len_d;
   logic [TMR_W-1:0]    timer_q, timer_d;
   logic [ADDR_W-1:0]   step_q,  step_d;
   logic [DATA_W-1:0]   leds_q,  leds_d;
   logic                busy_q,  busy_d;
   logic                done_q,  done_d;

   logic [LEN_W-1:0]    len_clamped;
   logic                last_step;

   // Requested length saturates at the ROM depth so step can never wrap.
   assign len_clamped = (32'(bus.length_i) > DEPTH) ? C_DEPTH : LEN_W'(bus.length_i);
   assign last_step   = ({1'b0, step_q} == (len_q - C_LEN_ONE));

   // The step counter doubles as the ROM address: both always advance together.
   assign bus.rom_address_o = step_q;
   assign bus.step_o        = step_q;
   assign bus.leds_o        = leds_q;
   assign bus.busy_o        = busy_q;
   assign bus.done_o        = done_q;

   // State and output registers, cleared asynchronously.
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= S_IDLE;
         len_q   <= '0;
         timer_q <= '0;
         step_q  <= '0;
         leds_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         timer_q <= timer_d;
         step_q  <= step_d;
         leds_q  <= leds_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state and next-output logic; abort overrides every non-idle state.
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      timer_d = timer_q;
      step_d  = step_q;
      leds_d  = leds_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            busy_d = 1'b0;
            leds_d = '0;
            if (bus.start_i && !bus.abort_i) begin
               len_d  = len_clamped;
               busy_d = 1'b1;
               if (len_clamped == C_LEN_ZERO) begin
                  // Nothing to play: address is left untouched.
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_FETCH;
                  step_d  = '0;
                  timer_d = '0;
               end
            end
         end
         S_FETCH: begin
            // ROM samples the address at the end of this cycle.
            state_d = S_LATCH;
         end
         S_LATCH: begin
            leds_d  = bus.rom_data_i;
            timer_d = '0;
            state_d = S_SHOW;
         end
         S_SHOW: begin
            if (timer_q == C_ON_LAST) begin
               leds_d  = '0;
               timer_d = '0;
               if (last_step) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_GAP;
               end
            end else begin
               timer_d = timer_q + C_TMR_ONE;
            end
         end
         S_GAP: begin
            if (timer_q == C_OFF_LAST) begin
               step_d  = step_q + C_STEP_ONE;
               timer_d = '0;
               state_d = S_FETCH;
            end else begin
               timer_d = timer_q + C_TMR_ONE;
            end
         end
         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (bus.abort_i && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         leds_d  = '0;
         busy_d  = 1'b0;
         step_d  = '0;
         timer_d = '0;
         done_d  = 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rom_sequence_player.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rom_sequence_player
//  Description : Self-checking bench for rom_sequence_player against a
//                cycle-count reference model plus pinned literal values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rom_sequence_player;

   localparam int ON  = 4;
   localparam int OFF = 2;
   localparam int P   = 2 + ON + OFF;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   rom_sequence_player_if #(.ADDR_W(3), .DATA_W(8)) bus ();

   rom_sequence_player #(
      .ON_CYCLES (ON),
      .OFF_CYCLES(OFF),
      .ADDR_W    (3),
      .DATA_W    (8)
   ) dut (
      .clock_i  (clk),
      .reset_n_i(rst_n),
      .bus      (bus)
   );

   // Pattern ROM with one clock of read latency
   logic [7:0] rom [8];
   always @(posedge clk) bus.rom_data_i <= rom[bus.rom_address_o];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model ----------------
   logic [7:0] e_leds;
   logic [2:0] e_step;
   logic       e_busy;
   logic       e_done;
   int         m_k;
   int         m_len;

   // Outputs as a function of cycles elapsed since the accepted start.
   task automatic eval_run();
      int t_done, i, r;
      t_done = (m_len == 0) ? 1 : (m_len - 1) * P + 2 + ON + 1;
      if (m_k == t_done) begin
         e_done = 1'b1; e_busy = 1'b1; e_leds = 8'h00;
         if (m_len != 0) e_step = 3'(m_len - 1);
      end else if (m_k > t_done) begin
         e_done = 1'b0; e_busy = 1'b0; e_leds = 8'h00;
      end else begin
         i = (m_k - 1) / P;
         r = (m_k - 1) % P;
         e_done = 1'b0; e_busy = 1'b1; e_step = 3'(i);
         e_leds = (r >= 2 && r < 2 + ON) ? rom[i] : 8'h00;
      end
   endtask

   always @(posedge clk or negedge rst_n) begin : model
      if (!rst_n) begin
         e_leds = 8'h00; e_step = 3'd0; e_busy = 1'b0; e_done = 1'b0;
         m_k = 0; m_len = 0;
      end else if (e_busy) begin
         if (bus.abort_i) begin
            e_leds = 8'h00; e_step = 3'd0; e_busy = 1'b0; e_done = 1'b0;
         end else begin
            m_k = m_k + 1;
            eval_run();
         end
      end else if (bus.start_i && !bus.abort_i) begin
         m_len = (bus.length_i > 4'd8) ? 8 : int'(bus.length_i);
         m_k   = 1;
         eval_run();
      end else begin
         e_leds = 8'h00; e_busy = 1'b0; e_done = 1'b0;
      end
   end

   // ---------------- checking ----------------
   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (act !== exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Hand-derived expectations: kind, cycle after start edge, signal, value.
   // signal: 0 leds, 1 busy, 2 done, 3 step
   typedef struct { int kind; int c; int sig; int val; } lit_t;
   lit_t lits [$];
   int   lit_kind = 0;
   int   lit_base = 0;

   function automatic logic [31:0] pick(input int sig);
      case (sig)
         0:       return 32'(bus.leds_o);
         1:       return 32'(bus.busy_o);
         2:       return 32'(bus.done_o);
         default: return 32'(bus.step_o);
      endcase
   endfunction

   initial begin : compare
      int rel;
      lits = '{
         '{1, 1,1,1}, '{1, 3,0,8'h01}, '{1, 6,0,8'h01}, '{1, 7,0,0}, '{1,11,0,8'h02},
         '{1,11,3,1}, '{1,14,0,8'h02}, '{1,15,0,0}, '{1,19,0,8'h04}, '{1,19,3,2},
         '{1,22,0,8'h04}, '{1,22,2,0}, '{1,23,2,1}, '{1,23,1,1}, '{1,24,1,0}, '{1,24,2,0},
         '{2, 1,2,1}, '{2, 1,1,1}, '{2, 1,0,0}, '{2, 2,2,0}, '{2, 2,1,0},
         '{3, 3,0,8'h01}, '{3,51,0,8'h40}, '{3,59,0,8'h80}, '{3,62,3,7},
         '{3,62,2,0}, '{3,63,2,1}, '{3,64,1,0},
         '{4,12,0,8'h02}, '{4,13,1,0}, '{4,13,0,0}, '{4,13,3,0}, '{4,14,2,0},
         '{4,15,1,1}, '{4,17,0,8'h01}, '{4,36,0,8'h04}, '{4,37,2,1}
      };
      forever begin
         @(negedge clk or negedge rst_n);
         #1;
         if (!rst_n) begin
            chk("rst_leds", 32'(bus.leds_o), 32'h0);
            chk("rst_busy", 32'(bus.busy_o), 32'h0);
            chk("rst_done", 32'(bus.done_o), 32'h0);
            chk("rst_step", 32'(bus.step_o), 32'h0);
            chk("rst_addr", 32'(bus.rom_address_o), 32'h0);
         end else begin
            chk("leds", 32'(bus.leds_o), 32'(e_leds));
            chk("busy", 32'(bus.busy_o), 32'(e_busy));
            chk("done", 32'(bus.done_o), 32'(e_done));
            chk("step", 32'(bus.step_o), 32'(e_step));
            chk("addr", 32'(bus.rom_address_o), 32'(e_step));
            rel = cyc - lit_base + 1;
            foreach (lits[j]) begin
               if (lits[j].kind == lit_kind && lits[j].c == rel)
                  chk($sformatf("lit k%0d c%0d s%0d", lit_kind, rel, lits[j].sig),
                      pick(lits[j].sig), 32'(lits[j].val));
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic play(input int len, input int kind, input int extra_at,
                       input int abort_at, input int restart_at, input int ncyc);
      @(negedge clk);
      bus.length_i = 4'(len);
      bus.start_i  = 1'b1;
      lit_kind     = kind;
      lit_base     = cyc + 1;
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk);
         bus.start_i = (c == extra_at) || (c == restart_at);
         bus.abort_i = (c == abort_at);
      end
      bus.start_i = 1'b0;
      bus.abort_i = 1'b0;
      lit_kind    = 0;
   endtask

   initial begin : stim
      bus.start_i  = 1'b0;
      bus.abort_i  = 1'b0;
      bus.length_i = 4'd0;
      for (int i = 0; i < 8; i++) rom[i] = 8'(1 << i);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      play(3, 1, 0, 0, 0, 28);     // basic three-step run
      play(3, 1, 5, 0, 0, 28);     // extra start mid-run is ignored
      play(8, 3, 0, 0, 0, 68);     // full ROM walk
      play(12, 3, 0, 0, 0, 68);    // clamped to 8
      play(0, 2, 0, 0, 0, 4);      // empty run
      play(3, 4, 0, 12, 14, 42);   // abort then restart

      // Asynchronous reset in the middle of the first SHOW phase
      @(negedge clk);
      bus.length_i = 4'd3;
      bus.start_i  = 1'b1;
      @(negedge clk);
      bus.start_i  = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Random traffic with random ROM contents
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         if (!e_busy && $urandom_range(0, 3) == 0)
            rom[$urandom_range(0, 7)] = 8'($urandom);
         bus.start_i  = ($urandom_range(0, 5) == 0);
         bus.length_i = 4'($urandom_range(0, 15));
         bus.abort_i  = ($urandom_range(0, (n < 1500) ? 200 : 20) == 0);
      end
      bus.start_i = 1'b0;
      bus.abort_i = 1'b0;
      repeat (5) @(negedge clk);
      #2;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
